// File: rtl/ps2_atom_keyboard.sv
// PS/2 set-2 keyboard receiver and decoder that maintains the Acorn Atom 10x6 key matrix
// plus SHIFT/CTRL/REPT flags, as read back by the PIO. F12 held raises the BREAK reset request.
module ps2_atom_keyboard #(
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [3:0] key_row,
    output logic [8:0] kbd_in,
    output logic       brk_req,
    output logic       frame_err
);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXTBRK} dec_state_e;

    logic [2:0]      ps2c_q, ps2c_d;
    logic [1:0]      ps2d_q, ps2d_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [9:0]      sr_q, sr_d;
    logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
    logic            byte_valid_q, byte_valid_d;
    logic [7:0]      byte_q, byte_d;
    logic            frame_err_q, frame_err_d;
    dec_state_e      state_q, state_d;
    logic [9:0][5:0] matrix_q, matrix_d;
    logic            shift_q, shift_d, ctrl_q, ctrl_d, rept_q, rept_d, brk_q, brk_d;
    logic [8:0]      kbd_in_q, kbd_in_d;

    logic            fall;
    logic            key_en, key_make;
    logic [7:0]      km;
    logic [5:0]      col_n;

    // Result is {hit, row[3:0], col[2:0]}; letters/digits not in the map are simply ignored.
    function automatic logic [7:0] keymap(input logic [7:0] code);
        logic [7:0] r;
        r = 8'h00;
        case (code)
            8'h76: r = {1'b1, 4'd0, 3'd5};  8'h21: r = {1'b1, 4'd1, 3'd5};
            8'h32: r = {1'b1, 4'd2, 3'd5};  8'h1C: r = {1'b1, 4'd3, 3'd5};
            8'h23: r = {1'b1, 4'd4, 3'd5};  8'h24: r = {1'b1, 4'd5, 3'd5};
            8'h2B: r = {1'b1, 4'd6, 3'd5};  8'h34: r = {1'b1, 4'd7, 3'd5};
            8'h33: r = {1'b1, 4'd8, 3'd5};  8'h43: r = {1'b1, 4'd9, 3'd5};
            8'h3B: r = {1'b1, 4'd0, 3'd3};  8'h42: r = {1'b1, 4'd1, 3'd3};
            8'h4B: r = {1'b1, 4'd2, 3'd3};  8'h3A: r = {1'b1, 4'd3, 3'd3};
            8'h31: r = {1'b1, 4'd4, 3'd3};  8'h4A: r = {1'b1, 4'd5, 3'd3};
            8'h44: r = {1'b1, 4'd6, 3'd3};  8'h4D: r = {1'b1, 4'd7, 3'd3};
            8'h15: r = {1'b1, 4'd8, 3'd3};  8'h2D: r = {1'b1, 4'd9, 3'd3};
            8'h1B: r = {1'b1, 4'd0, 3'd2};  8'h2C: r = {1'b1, 4'd1, 3'd2};
            8'h3C: r = {1'b1, 4'd2, 3'd2};  8'h2A: r = {1'b1, 4'd3, 3'd2};
            8'h1D: r = {1'b1, 4'd4, 3'd2};  8'h22: r = {1'b1, 4'd5, 3'd2};
            8'h35: r = {1'b1, 4'd6, 3'd2};  8'h1A: r = {1'b1, 4'd7, 3'd2};
            8'h1E: r = {1'b1, 4'd0, 3'd4};  8'h26: r = {1'b1, 4'd1, 3'd4};
            8'h25: r = {1'b1, 4'd2, 3'd4};  8'h2E: r = {1'b1, 4'd3, 3'd4};
            8'h36: r = {1'b1, 4'd4, 3'd4};  8'h3D: r = {1'b1, 4'd5, 3'd4};
            8'h3E: r = {1'b1, 4'd6, 3'd4};  8'h46: r = {1'b1, 4'd7, 3'd4};
            8'h16: r = {1'b1, 4'd8, 3'd4};  8'h45: r = {1'b1, 4'd9, 3'd4};
            8'h66: r = {1'b1, 4'd4, 3'd1};  8'h5A: r = {1'b1, 4'd6, 3'd1};
            8'h29: r = {1'b1, 4'd9, 3'd0};
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    always_comb begin
        ps2c_d       = {ps2c_q[1:0], ps2_clk};
        ps2d_d       = {ps2d_q[0], ps2_data};
        fall         = ps2c_q[2] & ~ps2c_q[1];
        bit_cnt_d    = bit_cnt_q;
        sr_d         = sr_q;
        idle_cnt_d   = idle_cnt_q;
        byte_valid_d = 1'b0;
        byte_d       = byte_q;
        frame_err_d  = 1'b0;

        // sr_q[0]=start, sr_q[8:1]=data, sr_q[9]=parity once ten bits are in; stop is the live sample.
        if (fall) begin
            idle_cnt_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                if (!sr_q[0] && (^sr_q[9:1]) && ps2d_q[1]) begin
                    byte_valid_d = 1'b1;
                    byte_d       = sr_q[8:1];
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                sr_d      = {ps2d_q[1], sr_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (idle_cnt_q == IW'(TIMEOUT_CYCLES)) begin
            bit_cnt_d = 4'd0;
        end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end

        state_d  = state_q;
        key_en   = 1'b0;
        key_make = 1'b1;
        if (byte_valid_q) begin
            case (state_q)
                S_IDLE: begin
                    if (byte_q == 8'hF0)      state_d = S_BRK;
                    else if (byte_q == 8'hE0) state_d = S_EXT;
                    else if (byte_q != 8'hE1) key_en = 1'b1;
                end
                S_BRK: begin
                    key_en   = 1'b1;
                    key_make = 1'b0;
                    state_d  = S_IDLE;
                end
                S_EXT: begin
                    if (byte_q == 8'hF0) begin
                        state_d = S_EXTBRK;
                    end else begin
                        key_en  = (byte_q == 8'h14);
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    key_en   = (byte_q == 8'h14);
                    key_make = 1'b0;
                    state_d  = S_IDLE;
                end
            endcase
        end

        km       = keymap(byte_q);
        matrix_d = matrix_q;
        shift_d  = shift_q;
        ctrl_d   = ctrl_q;
        rept_d   = rept_q;
        brk_d    = brk_q;
        if (key_en) begin
            case (byte_q)
                8'h12, 8'h59: shift_d = key_make;
                8'h14:        ctrl_d  = key_make;
                8'h11:        rept_d  = key_make;
                8'h07:        brk_d   = key_make;
                default: if (km[7]) matrix_d[km[6:3]][km[2:0]] = key_make;
            endcase
        end

        // Rows 10..15 select nothing, so their columns read as released.
        col_n = 6'h3F;
        for (int r = 0; r < 10; r++) begin
            if (key_row == 4'(r)) col_n = ~matrix_d[r];
        end
        kbd_in_d = {~rept_d, ~shift_d, ~ctrl_d, col_n};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps2c_q       <= 3'b111;
            ps2d_q       <= 2'b11;
            bit_cnt_q    <= 4'd0;
            sr_q         <= '0;
            idle_cnt_q   <= '0;
            byte_valid_q <= 1'b0;
            byte_q       <= 8'h00;
            frame_err_q  <= 1'b0;
            state_q      <= S_IDLE;
            matrix_q     <= '0;
            shift_q      <= 1'b0;
            ctrl_q       <= 1'b0;
            rept_q       <= 1'b0;
            brk_q        <= 1'b0;
            kbd_in_q     <= 9'h1FF;
        end else begin
            ps2c_q       <= ps2c_d;
            ps2d_q       <= ps2d_d;
            bit_cnt_q    <= bit_cnt_d;
            sr_q         <= sr_d;
            idle_cnt_q   <= idle_cnt_d;
            byte_valid_q <= byte_valid_d;
            byte_q       <= byte_d;
            frame_err_q  <= frame_err_d;
            state_q      <= state_d;
            matrix_q     <= matrix_d;
            shift_q      <= shift_d;
            ctrl_q       <= ctrl_d;
            rept_q       <= rept_d;
            brk_q        <= brk_d;
            kbd_in_q     <= kbd_in_d;
        end
    end

    assign kbd_in    = kbd_in_q;
    assign brk_req   = brk_q;
    assign frame_err = frame_err_q;
endmodule
